memory_master: RTL and testbench
================================

# memory_master

Synchronous initiator for the single-port asynchronous `Memory` block (enable / readwrite / 6-bit address / 4-bit data). It accepts one read or write request at a time on a valid/ready host port and sequences the memory control pins with a fixed setup and access window. It captures read data and returns one response per request on a valid/ready response port. It sits between any clocked client (CPU stub, DMA, test sequencer) and `Memory`, so clients never drive the memory pins directly.

## Interface
- `DATA_WIDTH`, 4: memory data width.
- `ADDR_WIDTH`, 6: memory address width.
- `WAIT_CYCLES`, 1: cycles `memEnable` stays high per access; legal range 1..15.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `reqValid` input 1: host request present.
- `reqReady` output 1: the block accepts a request this cycle.
- `reqWrite` input 1: 1 = write, 0 = read.
- `reqAddress` input ADDR_WIDTH: target address.
- `reqData` input DATA_WIDTH: write data; ignored for reads.
- `rspValid` output 1: response present.
- `rspReady` input 1: host consumes the response.
- `rspWrite` output 1: echo of the request's `reqWrite`.
- `rspData` output DATA_WIDTH: read data; 0 for writes.
- `memEnable` output 1: to `Memory.enable`.
- `memReadwrite` output 1: to `Memory.readwrite` (1 = read, 0 = write).
- `memAddress` output ADDR_WIDTH: to `Memory.address`.
- `memDataIn` output DATA_WIDTH: to `Memory.dataIn`.
- `memDataOut` input DATA_WIDTH: from `Memory.dataOut`.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. The reset state is IDLE.
- `reqReady` = (state == IDLE). It is combinational from the state register only and never depends on `reqValid`.
- **IDLE:** on `reqValid && reqReady`, register `reqWrite`, `reqAddress` and `reqData`, then go to SETUP.
- **SETUP (1 cycle):**
  - `memAddress` and `memDataIn` drive the registered values.
  - `memReadwrite` = !write.
  - `memEnable` = 0.
  - Go to ACCESS and load the wait counter with `WAIT_CYCLES-1`.
- **ACCESS (`WAIT_CYCLES` cycles):**
  - `memEnable` = 1.
  - Address, data and `memReadwrite` stay stable.
  - The counter decrements each cycle.
  - On the edge that leaves ACCESS (counter == 0):
    - Reads: capture `memDataOut` into `rspData`.
    - Writes: `rspData` ← 0.
    - In both cases `rspWrite` ← write.
  - Then go to RESP.
- **RESP:**
  - `memEnable` = 0 and `memReadwrite` = 1 (safe read default).
  - `rspValid` = 1 and stays asserted until `rspReady`. `rspData` and `rspWrite` stay stable while `rspValid && !rspReady`.
  - On `rspValid && rspReady`, go to IDLE.
- `memAddress` and `memDataIn` hold their last values outside a transaction; they change only on request accept.
- `memReadwrite` never changes while `memEnable` = 1.
- Requests presented outside IDLE are not accepted, and the host holds them.
- Address range 0..2^ADDR_WIDTH-1 has no wrap or translation; address 63 is passed through unchanged.

## Timing
- **Reset values (rstn low, immediate):**
  - State IDLE.
  - `memEnable` 0, `memReadwrite` 1, `memAddress` 0, `memDataIn` 0.
  - `rspValid` 0, `rspData` 0, `rspWrite` 0, wait counter 0.
  - `reqReady` 1 while held in reset.
- **Reset mid-operation:** `memEnable` drops asynchronously and the in-flight request is discarded with no response. A write aborted in ACCESS may or may not have landed in memory.
- **Latency:** request accepted at edge N; SETUP in cycle N+1; ACCESS in cycles N+2..N+1+W; `rspValid` high from cycle N+2+W.
- **Throughput:** with `rspReady` tied high, one transaction per 3+W cycles. The next request is accepted no earlier than the cycle after the response handshake.
- **Response handshake:** the response completes on the edge where `rspValid && rspReady`. `rspValid` falls the following cycle.

## Test plan
- **Write/readback, W=1:** write 1←1010, 2←1100, 3←0101, then read 1, 2, 3 → `rspData` 1010, 1100, 0101 with `rspWrite` 0. Each write response has `rspWrite` 1 and `rspData` 0000. `rspValid` rises exactly 3 cycles after accept.
- **Latency, W=3:** read of address 2 → `memEnable` high for exactly 3 cycles. `rspValid` rises 5 cycles after accept. `memReadwrite` stays stable while `memEnable` is high.
- **Backpressure:** hold `rspReady` low for 4 cycles after a read of address 3 → `rspValid` stays 1 and `rspData` stays 0101. `reqReady` stays 0 and a pending `reqValid` is not accepted until one cycle after `rspReady` rises.
- **Boundary address:** write 63←1111, then read 63 → 1111. Address 0 is unaffected (still 0000 if never written).
- **Reset mid-access:** assert `rstn` low during ACCESS of a write → `memEnable` 0 the same cycle, no `rspValid`, and all outputs at their reset values. After release, `reqReady` is 1 and a fresh read completes normally.
- **Idle pins:** with no requests for 10 cycles → `memEnable` 0, `memReadwrite` 1, and `memAddress`/`memDataIn` unchanged from the last transaction.

Source files
------------

// File: rtl/memory_master.sv
// Clocked initiator for the single-port asynchronous Memory block: one read or
// write per request, fixed setup cycle, WAIT_CYCLES access window, held response.
module memory_master #(
   parameter int DATA_WIDTH  = 4,
   parameter int ADDR_WIDTH  = 6,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  reqValid,
   output logic                  reqReady,
   input  logic                  reqWrite,
   input  logic [ADDR_WIDTH-1:0] reqAddress,
   input  logic [DATA_WIDTH-1:0] reqData,
   output logic                  rspValid,
   input  logic                  rspReady,
   output logic                  rspWrite,
   output logic [DATA_WIDTH-1:0] rspData,
   output logic                  memEnable,
   output logic                  memReadwrite,
   output logic [ADDR_WIDTH-1:0] memAddress,
   output logic [DATA_WIDTH-1:0] memDataIn,
   input  logic [DATA_WIDTH-1:0] memDataOut
);

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t             state, state_next;
   logic               write_q;
   logic [CNT_W-1:0]   wait_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   // Pin controls decode from the state register alone, so an asynchronous
   // reset drops memEnable immediately and memReadwrite cannot move mid-access.
   always_comb begin
      state_next   = state;
      reqReady     = 1'b0;
      rspValid     = 1'b0;
      memEnable    = 1'b0;
      memReadwrite = 1'b1;
      case (state)
         IDLE: begin
            reqReady = 1'b1;
            if (reqValid) state_next = SETUP;
         end
         SETUP: begin
            memReadwrite = !write_q;
            state_next   = ACCESS;
         end
         ACCESS: begin
            memEnable    = 1'b1;
            memReadwrite = !write_q;
            if (wait_cnt == '0) state_next = RESP;
         end
         RESP: begin
            rspValid = 1'b1;
            if (rspReady) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         write_q    <= 1'b0;
         memAddress <= '0;
         memDataIn  <= '0;
         wait_cnt   <= '0;
         rspData    <= '0;
         rspWrite   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (reqValid) begin
                  write_q    <= reqWrite;
                  memAddress <= reqAddress;
                  memDataIn  <= reqData;
               end
            end
            SETUP: wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
            ACCESS: begin
               if (wait_cnt == '0) begin
                  rspData  <= write_q ? '0 : memDataOut;
                  rspWrite <= write_q;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_master.sv
// Directed bench for memory_master: W=1 instance with a behavioural memory for
// data path, backpressure, reset and idle checks; W=3 instance for latency.
module tb_memory_master;

   logic       clk = 1'b0;
   logic       rstn;
   always #5 clk = ~clk;

   // W=1 instance
   logic       reqValid, reqReady, reqWrite;
   logic [5:0] reqAddress;
   logic [3:0] reqData;
   logic       rspValid, rspReady, rspWrite;
   logic [3:0] rspData;
   logic       memEnable, memReadwrite;
   logic [5:0] memAddress;
   logic [3:0] memDataIn, memDataOut;

   // W=3 instance
   logic       v3_reqValid, v3_reqReady, v3_reqWrite;
   logic [5:0] v3_reqAddress;
   logic [3:0] v3_reqData;
   logic       v3_rspValid, v3_rspReady, v3_rspWrite;
   logic [3:0] v3_rspData;
   logic       v3_memEnable, v3_memReadwrite;
   logic [5:0] v3_memAddress;
   logic [3:0] v3_memDataIn, v3_memDataOut;

   memory_master #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WAIT_CYCLES(1)) dut1 (
      .clk(clk), .rstn(rstn),
      .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
      .reqAddress(reqAddress), .reqData(reqData),
      .rspValid(rspValid), .rspReady(rspReady), .rspWrite(rspWrite), .rspData(rspData),
      .memEnable(memEnable), .memReadwrite(memReadwrite), .memAddress(memAddress),
      .memDataIn(memDataIn), .memDataOut(memDataOut)
   );

   memory_master #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rstn(rstn),
      .reqValid(v3_reqValid), .reqReady(v3_reqReady), .reqWrite(v3_reqWrite),
      .reqAddress(v3_reqAddress), .reqData(v3_reqData),
      .rspValid(v3_rspValid), .rspReady(v3_rspReady), .rspWrite(v3_rspWrite),
      .rspData(v3_rspData),
      .memEnable(v3_memEnable), .memReadwrite(v3_memReadwrite),
      .memAddress(v3_memAddress), .memDataIn(v3_memDataIn), .memDataOut(v3_memDataOut)
   );

   // Behavioural memory for the W=1 instance; writes land while enabled for write.
   logic [3:0] mem1 [64] = '{default: '0};
   assign memDataOut = mem1[memAddress];
   always @(posedge clk) begin
      if (memEnable && !memReadwrite) mem1[memAddress] <= memDataIn;
   end

   // Fixed read-only contents for the W=3 instance.
   assign v3_memDataOut = (v3_memAddress == 6'd2) ? 4'h6 : 4'h0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One complete transaction on dut1 with rspReady high; returns the response
   // and the number of cycles from accept edge to rspValid.
   task automatic run(input logic w, input logic [5:0] a, input logic [3:0] d,
                      output logic [3:0] rd, output logic rw, output int lat,
                      output bit tmo);
      int n;
      tmo = 1'b0;
      @(negedge clk);
      reqValid = 1'b1; reqWrite = w; reqAddress = a; reqData = d;
      n = 0;
      while (!reqReady && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) tmo = 1'b1;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         reqValid = 1'b0;
         lat++;
      end while (!rspValid && lat < 50);
      if (lat >= 50) tmo = 1'b1;
      rd = rspData;
      rw = rspWrite;
   endtask

   typedef struct {
      logic       write;
      logic [5:0] addr;
      logic [3:0] data;
      logic [3:0] exp_data;
      logic       exp_write;
   } vec_t;

   vec_t vecs [9];

   initial begin
      logic [3:0] rd;
      logic       rw;
      int         lat;
      bit         tmo;
      int         en_cnt;
      bit         rw_moved;

      vecs[0] = '{1'b1, 6'd1,  4'b1010, 4'b0000, 1'b1};
      vecs[1] = '{1'b1, 6'd2,  4'b1100, 4'b0000, 1'b1};
      vecs[2] = '{1'b1, 6'd3,  4'b0101, 4'b0000, 1'b1};
      vecs[3] = '{1'b0, 6'd1,  4'h9,    4'b1010, 1'b0};
      vecs[4] = '{1'b0, 6'd2,  4'h9,    4'b1100, 1'b0};
      vecs[5] = '{1'b0, 6'd3,  4'h9,    4'b0101, 1'b0};
      vecs[6] = '{1'b1, 6'd63, 4'b1111, 4'b0000, 1'b1};
      vecs[7] = '{1'b0, 6'd0,  4'h9,    4'b0000, 1'b0};
      vecs[8] = '{1'b0, 6'd63, 4'h9,    4'b1111, 1'b0};

      rstn = 1'b0;
      reqValid = 1'b0; reqWrite = 1'b0; reqAddress = '0; reqData = '0; rspReady = 1'b1;
      v3_reqValid = 1'b0; v3_reqWrite = 1'b0; v3_reqAddress = '0; v3_reqData = '0;
      v3_rspReady = 1'b1;

      #3;
      check("rst_reqReady",     32'(reqReady),     32'd1);
      check("rst_memEnable",    32'(memEnable),    32'd0);
      check("rst_memReadwrite", 32'(memReadwrite), 32'd1);
      check("rst_memAddress",   32'(memAddress),   32'd0);
      check("rst_memDataIn",    32'(memDataIn),    32'd0);
      check("rst_rspValid",     32'(rspValid),     32'd0);
      check("rst_rspData",      32'(rspData),      32'd0);
      check("rst_rspWrite",     32'(rspWrite),     32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run(vecs[i].write, vecs[i].addr, vecs[i].data, rd, rw, lat, tmo);
         check($sformatf("vec%0d_timeout", i), 32'(tmo), 32'd0);
         check($sformatf("vec%0d_rspData", i), 32'(rd), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d_rspWrite", i), 32'(rw), 32'(vecs[i].exp_write));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      end

      // Idle pins: last transaction was a read of 63 with reqData 9
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_memEnable",    32'(memEnable),    32'd0);
         check("idle_memReadwrite", 32'(memReadwrite), 32'd1);
         check("idle_memAddress",   32'(memAddress),   32'd63);
         check("idle_memDataIn",    32'(memDataIn),    32'h9);
      end

      // Latency on the W=3 instance: read address 2
      @(negedge clk);
      v3_reqValid = 1'b1; v3_reqWrite = 1'b0; v3_reqAddress = 6'd2; v3_reqData = 4'h0;
      check("w3_reqReady", 32'(v3_reqReady), 32'd1);
      @(posedge clk);
      lat = 0; en_cnt = 0; rw_moved = 1'b0;
      do begin
         @(negedge clk);
         v3_reqValid = 1'b0;
         lat++;
         if (v3_memEnable) begin
            en_cnt++;
            if (v3_memReadwrite !== 1'b1) rw_moved = 1'b1;
         end
      end while (!v3_rspValid && lat < 50);
      check("w3_latency",      32'(lat),         32'd5);
      check("w3_enable_cycles", 32'(en_cnt),     32'd3);
      check("w3_rw_stable",    32'(rw_moved),    32'd0);
      check("w3_rspData",      32'(v3_rspData),  32'h6);
      check("w3_rspWrite",     32'(v3_rspWrite), 32'd0);

      // Backpressure: read 3 with rspReady low, a second request pending
      @(negedge clk);
      rspReady = 1'b0;
      reqValid = 1'b1; reqWrite = 1'b0; reqAddress = 6'd3; reqData = 4'h0;
      @(posedge clk);
      @(negedge clk);
      reqAddress = 6'd1;
      lat = 1;
      while (!rspValid && lat < 50) begin @(negedge clk); lat++; end
      check("bp_latency", 32'(lat), 32'd3);
      for (int i = 0; i < 4; i++) begin
         check("bp_rspValid", 32'(rspValid), 32'd1);
         check("bp_rspData",  32'(rspData),  32'b0101);
         check("bp_reqReady", 32'(reqReady), 32'd0);
         @(negedge clk);
      end
      rspReady = 1'b1;
      check("bp_release_reqReady", 32'(reqReady), 32'd0);
      @(negedge clk);
      check("bp_after_rspValid", 32'(rspValid), 32'd0);
      check("bp_after_reqReady", 32'(reqReady), 32'd1);
      @(negedge clk);
      check("bp_pending_accepted", 32'(reqReady), 32'd0);
      reqValid = 1'b0;
      lat = 1;
      while (!rspValid && lat < 50) begin @(negedge clk); lat++; end
      check("bp_pending_latency", 32'(lat), 32'd3);
      check("bp_pending_rspData", 32'(rspData), 32'b1010);

      // Reset during ACCESS of a write
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqAddress = 6'd5; reqData = 4'h7;
      @(posedge clk);
      @(negedge clk);
      reqValid = 1'b0;
      @(negedge clk);
      check("ra_in_access", 32'(memEnable), 32'd1);
      #1 rstn = 1'b0;
      #1;
      check("ra_memEnable",    32'(memEnable),    32'd0);
      check("ra_memReadwrite", 32'(memReadwrite), 32'd1);
      check("ra_memAddress",   32'(memAddress),   32'd0);
      check("ra_memDataIn",    32'(memDataIn),    32'd0);
      check("ra_rspValid",     32'(rspValid),     32'd0);
      check("ra_reqReady",     32'(reqReady),     32'd1);
      @(negedge clk);
      rstn = 1'b1;
      check("ra_released_rspValid", 32'(rspValid), 32'd0);
      run(1'b0, 6'd1, 4'h0, rd, rw, lat, tmo);
      check("ra_read_timeout", 32'(tmo), 32'd0);
      check("ra_read_rspData", 32'(rd),  32'b1010);
      check("ra_read_latency", 32'(lat), 32'd3);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
